// File: rtl/prog_ste_chain.sv
// Programmable chain of state-transition elements (STEs) matching a byte stream,
// with a FIFO of {position, reporting-STE vector} entries and a sticky overflow flag.
module prog_ste_chain #(
  parameter int N_STE      = 12,
  parameter int POS_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(N_STE)-1:0]   cfg_ste,
  input  logic [7:0]                 cfg_sym,
  input  logic                       cfg_bit,
  input  logic                       cfg_attr_we,
  input  logic [3:0]                 cfg_attr,
  input  logic                       run,
  input  logic [7:0]                 symbols,
  output logic                       report_valid,
  input  logic                       report_ready,
  output logic [POS_W-1:0]           report_pos,
  output logic [N_STE-1:0]           report_vec,
  output logic                       overflow,
  output logic [N_STE-1:0]           active
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = POS_W + N_STE;

  logic                 cfg_ok;
  logic [N_STE-1:0]     active_q, active_d;
  logic [N_STE-1:0]     chain_in, enable, next_active, rep_mask, hit;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 sod_q, sod_d;

  logic [ENT_W-1:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 push, pop, full, do_write;
  logic [ENT_W-1:0]     head;

  // Configuration is only accepted while the matcher is idle and the index is in range.
  assign cfg_ok   = !run && (32'(cfg_ste) < N_STE);
  assign chain_in = {active_q[N_STE-2:0], 1'b0};

  for (genvar gi = 0; gi < N_STE; gi++) begin : g_ste
    logic [255:0] bitmap_q, bitmap_d;
    logic [3:0]   attr_q, attr_d;
    logic         sel;

    assign sel = cfg_ok && (32'(cfg_ste) == gi);

    always_comb begin
      bitmap_d = bitmap_q;
      attr_d   = attr_q;
      if (sel && cfg_we) bitmap_d[cfg_sym] = cfg_bit;
      if (sel && cfg_attr_we) attr_d = cfg_attr;
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        bitmap_q <= '0;
        attr_q   <= '0;
      end else begin
        bitmap_q <= bitmap_d;
        attr_q   <= attr_d;
      end
    end

    // Start type 3 is reserved and behaves as "no start".
    assign enable[gi] = (attr_q[1:0] == 2'd2)
                      | ((attr_q[1:0] == 2'd1) & sod_q)
                      | chain_in[gi]
                      | (attr_q[2] & active_q[gi]);
    assign next_active[gi] = enable[gi] & bitmap_q[symbols];
    assign rep_mask[gi]    = attr_q[3];
  end

  always_comb begin
    active_d = active_q;
    pos_d    = pos_q;
    sod_d    = sod_q;
    if (run) begin
      active_d = next_active;
      pos_d    = pos_q + POS_W'(1);
      sod_d    = 1'b0;
    end
  end

  assign hit      = next_active & rep_mask;
  assign push     = run && (hit != '0);
  assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign pop      = report_valid && report_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_write = push && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_write) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_write && !pop) count_d = count_q + (PTR_W+1)'(1);
    else if (!do_write && pop) count_d = count_q - (PTR_W+1)'(1);
    if (push && !do_write) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q   <= '0;
      pos_q      <= '0;
      sod_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      active_q   <= active_d;
      pos_q      <= pos_d;
      sod_q      <= sod_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && do_write) fifo_mem_q[wr_ptr_q] <= {pos_q, hit};
  end

  assign head         = fifo_mem_q[rd_ptr_q];
  assign report_valid = (count_q != '0);
  assign report_pos   = report_valid ? head[ENT_W-1:N_STE] : '0;
  assign report_vec   = report_valid ? head[N_STE-1:0] : '0;
  assign overflow     = overflow_q;
  assign active       = active_q;

endmodule
